mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, with the MEM/WB pipeline register built in. Sits between EX/MEM and WB.
- Drives the data-memory bus with a wait-state handshake.
- Generates byte strobes and store-data replication.
- Right-aligns load data by the byte offset, so WB only sign- or zero-extends by funct3.
- Stalls the upstream pipeline while an access is pending and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255, max wait cycles in BUSY before abort; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  valid instruction in EX/MEM
- ex_MemRead  in  1  load
- ex_MemWrite  in  1  store
- ex_RegWrite  in  1  writes rd
- ex_MemtoReg  in  1  WB selects memory data
- ex_funct3  in  3  access size/sign
- ex_rd  in  5  destination register
- ex_alu_result  in  32  effective address / ALU result
- ex_rs2_data  in  32  store data
- dmem_req  out  1  bus request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address
- dmem_wstrb  out  4  byte strobes
- dmem_wdata  out  32  store data
- dmem_ready  in  1  access complete this cycle; rdata valid
- dmem_rdata  in  32  read data
- mem_stall  out  1  freeze PC/IF/ID/EX and EX/MEM
- wb_valid  out  1  MEM/WB valid
- wb_RegWrite  out  1  MEM/WB RegWrite
- wb_MemtoReg  out  1  MEM/WB MemtoReg
- wb_funct3  out  3  MEM/WB funct3
- wb_rd  out  5  MEM/WB rd
- wb_Mem_out  out  32  right-aligned load data
- wb_rd_data  out  32  ALU result
- wb_misaligned  out  1  misaligned access exception
- wb_bus_err  out  1  timeout exception

Behaviour:
- Reset:
  - All wb_* outputs are 0; the FSM goes to IDLE; the counter is 0.
  - dmem_req and mem_stall are forced 0 while rst is high.
  - Reset mid-access drops dmem_req immediately; no MEM/WB capture occurs.
- Definitions:
  - mem_op = ex_valid & (ex_MemRead | ex_MemWrite).
  - off = ex_alu_result[1:0].
  - Size comes from funct3[1:0]: 00 byte, 01 half, 10/11 word.
- Alignment:
  - misaligned = mem_op & ((half & off[0]) | (word & off != 0)).
  - A misaligned access never requests the bus.
  - It is captured next edge with wb_misaligned=1 and wb_RegWrite=0, with no stall.
- Bus outputs:
  - dmem_addr = {ex_alu_result[31:2], 2'b00}.
  - dmem_we = ex_MemWrite.
- Store strobes and data:
  - SB: wstrb = 4'b0001<<off, wdata = byte replicated x4.
  - SH: wstrb = 4'b0011<<off, wdata = half replicated x2.
  - SW: wstrb = 4'b1111, wdata = rs2 unchanged.
  - Loads: wstrb = 0.
- FSM (IDLE, BUSY):
  - In IDLE, dmem_req = mem_op & ~misaligned.
  - If dmem_ready is high the same cycle, capture at the edge: zero wait states, no stall.
  - If dmem_ready is low, go to BUSY.
  - In BUSY, dmem_req = 1 and address/strobe/data stay stable because the upstream is frozen.
  - On dmem_ready, capture and return to IDLE.
  - The counter increments each BUSY cycle. When it equals TIMEOUT (≠0) without ready: abort, capture with wb_bus_err=1, wb_RegWrite=0, wb_Mem_out=0, return to IDLE.
  - The counter clears on leaving BUSY.
- Stall:
  - mem_stall = dmem_req & ~dmem_ready & ~timeout_hit.
- Capture:
  - Occurs when mem_stall=0. The MEM/WB register loads ex_* fields.
  - wb_Mem_out = dmem_rdata >> (8*off) for loads, 0 otherwise.
  - wb_rd_data = ex_alu_result.
- Stalled cycles:
  - While mem_stall=1, MEM/WB loads a bubble: wb_valid=0, wb_RegWrite=0, flags 0.
  - WB never sees duplicates.
- Other inputs:
  - Non-memory valid instructions pass through in 1 cycle.
  - ex_valid=0 produces a bubble.
  - Stores always capture with wb_RegWrite=0 regardless of the input.
  - rd=x0 passes unchanged; the register file ignores it.
- Simultaneous events: dmem_ready and timeout in the same cycle resolve as ready (success).
- Latency: 1 cycle plus memory wait states.

Decomposition:
- Shared package:
  - funct3 size/sign constants (LB/LH/LW/LBU/LHU, SB/SH/SW).
  - FSM state encoding IDLE/BUSY.
  - Width constants XLEN=32 and REG_AW=5.
- Sub-module st_align:
  - Combinational store strobe/data generation and misalignment detect from funct3 and off.
  - Shared later with any store buffer.

Test Plan:
- SW 0xDEADBEEF to 0x100, ready same cycle:
  - req=1, wstrb=1111, wdata=0xDEADBEEF, no stall.
  - Next cycle wb_valid=1, wb_RegWrite=0.
- LB from 0x103, rdata=0x80AABBCC, ready after 3 wait cycles:
  - mem_stall high for exactly 3 cycles with bubbles in MEM/WB.
  - Then wb_Mem_out=0x00000080, wb_funct3=000.
- SH 0x1234 to 0x102:
  - wstrb=1100, wdata=0x12341234.
  - LH to 0x101: no req, wb_misaligned=1, wb_RegWrite=0, no stall.
- TIMEOUT=4, ready never asserted:
  - Stall for 4 cycles, then capture with wb_bus_err=1, wb_Mem_out=0, FSM in IDLE, req drops.
- rst asserted during BUSY:
  - dmem_req, mem_stall and all wb_* go to 0 asynchronously.
  - After release, an ADD (rd=5, result 7) passes: wb_rd=5, wb_rd_data=7 one cycle later.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-access stage: access sizes,
// FSM encoding, datapath widths and the MEM/WB register layout.
package mem_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size taken from funct3[1:0]; 2'b10 and 2'b11 are both word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // MEM/WB pipeline register contents
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   mem_out;
    logic [XLEN-1:0]   rd_data;
    logic              misaligned;
    logic              bus_err;
  } wb_t;

  // Byte-lane mask for an access of the given size at offset 0
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_mask = 4'b0001;
      SZ_HALF: size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Signal bundle between EX/MEM, the data-memory bus and WB.
//
// Bus handshake: dmem_req is a valid that stays high until dmem_ready is
// seen high; while dmem_req & ~dmem_ready, dmem_we/addr/wstrb/wdata are
// held stable. The cycle with dmem_req & dmem_ready completes the access
// and dmem_rdata is valid in that same cycle. dmem_ready without dmem_req
// is ignored.
interface mem_stage_if;
  import mem_stage_pkg::*;

  // EX/MEM side
  logic              ex_valid;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              ex_RegWrite;
  logic              ex_MemtoReg;
  logic [2:0]        ex_funct3;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_alu_result;
  logic [XLEN-1:0]   ex_rs2_data;

  // Data-memory bus
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [3:0]        dmem_wstrb;
  logic [XLEN-1:0]   dmem_wdata;
  logic              dmem_ready;
  logic [XLEN-1:0]   dmem_rdata;

  // Pipeline control and MEM/WB outputs
  logic              mem_stall;
  logic              wb_valid;
  logic              wb_RegWrite;
  logic              wb_MemtoReg;
  logic [2:0]        wb_funct3;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_Mem_out;
  logic [XLEN-1:0]   wb_rd_data;
  logic              wb_misaligned;
  logic              wb_bus_err;

  // Debug view of the access FSM
  logic [0:0]        dbg_state;

  // The stage itself
  modport slave (
    input  ex_valid, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg,
    input  ex_funct3, ex_rd, ex_alu_result, ex_rs2_data,
    input  dmem_ready, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output mem_stall, wb_valid, wb_RegWrite, wb_MemtoReg, wb_funct3, wb_rd,
    output wb_Mem_out, wb_rd_data, wb_misaligned, wb_bus_err, dbg_state
  );

  // The surrounding pipeline and memory
  modport master (
    output ex_valid, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg,
    output ex_funct3, ex_rd, ex_alu_result, ex_rs2_data,
    output dmem_ready, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  mem_stall, wb_valid, wb_RegWrite, wb_MemtoReg, wb_funct3, wb_rd,
    input  wb_Mem_out, wb_rd_data, wb_misaligned, wb_bus_err, dbg_state
  );

endinterface

// File: rtl/mem_stage_st_align.sv
// Store lane steering: byte strobes, replicated store data and the
// alignment check for an access of a given size at a given byte offset.
// Purely combinational so a store buffer can reuse it.
module mem_stage_st_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misaligned_o
);

  // Strobes shifted to the offset, data replicated so every lane carries it
  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = rs2_i;
    case (size_i)
      SZ_BYTE: begin
        wstrb_o = size_mask(size_i) << off_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      SZ_HALF: begin
        wstrb_o = size_mask(size_i) << off_i;
        wdata_o = {2{rs2_i[15:0]}};
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = rs2_i;
      end
    endcase
  end

  // Halves need an even offset, words need offset zero
  always_comb begin
    misaligned_o = ((size_i == SZ_HALF) & off_i[0]) |
                   (size_i[1] & (off_i != 2'b00));
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage with built-in MEM/WB register. Issues the data bus
// request, freezes the upstream pipeline while the bus inserts wait
// states, aborts after TIMEOUT wait cycles, and right-aligns load data.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic             mem_op;
  logic             mis_raw;
  logic             misaligned;
  logic             is_load;
  logic             req;
  logic             stall;
  logic             timeout_hit;
  logic [1:0]       off;
  logic [3:0]       st_wstrb;
  logic [XLEN-1:0]  st_wdata;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_t              wb_q, wb_d;

  mem_stage_st_align u_st_align (
    .size_i       (bus.ex_funct3[1:0]),
    .off_i        (off),
    .rs2_i        (bus.ex_rs2_data),
    .wstrb_o      (st_wstrb),
    .wdata_o      (st_wdata),
    .misaligned_o (mis_raw)
  );

  // Request, abort and stall decisions for the current cycle
  always_comb begin
    off         = bus.ex_alu_result[1:0];
    mem_op      = bus.ex_valid & (bus.ex_MemRead | bus.ex_MemWrite);
    misaligned  = mem_op & mis_raw;
    is_load     = bus.ex_MemRead & ~bus.ex_MemWrite;
    // In BUSY the upstream is frozen, so the held request is still valid
    req         = ~rst & ((state_q == ST_BUSY) | (mem_op & ~misaligned));
    // cnt_q counts wait cycles already spent, including the first IDLE one
    timeout_hit = (TIMEOUT != 0) & (state_q == ST_BUSY) & (cnt_q == TMO) &
                  ~bus.dmem_ready;
    stall       = req & ~bus.dmem_ready & ~timeout_hit;
  end

  assign bus.dmem_req   = req;
  assign bus.mem_stall  = stall;
  assign bus.dmem_we    = bus.ex_MemWrite;
  assign bus.dmem_addr  = {bus.ex_alu_result[XLEN-1:2], 2'b00};
  assign bus.dmem_wstrb = bus.ex_MemWrite ? st_wstrb : 4'b0000;
  assign bus.dmem_wdata = st_wdata;
  assign bus.dbg_state  = state_q;

  // Access FSM: leave IDLE only when the bus inserts a wait state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req & ~bus.dmem_ready) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (bus.dmem_ready | timeout_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next MEM/WB contents: a bubble while stalled or for an invalid slot
  always_comb begin
    wb_d = '0;
    if (~stall & bus.ex_valid) begin
      wb_d.valid      = 1'b1;
      wb_d.reg_write  = bus.ex_RegWrite & ~bus.ex_MemWrite & ~misaligned &
                        ~timeout_hit;
      wb_d.mem_to_reg = bus.ex_MemtoReg;
      wb_d.funct3     = bus.ex_funct3;
      wb_d.rd         = bus.ex_rd;
      wb_d.rd_data    = bus.ex_alu_result;
      wb_d.misaligned = misaligned;
      wb_d.bus_err    = timeout_hit;
      if (mem_op & is_load & ~misaligned & ~timeout_hit) begin
        wb_d.mem_out = bus.dmem_rdata >> {off, 3'b000};
      end
    end
  end

  // FSM state and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign bus.wb_valid      = wb_q.valid;
  assign bus.wb_RegWrite   = wb_q.reg_write;
  assign bus.wb_MemtoReg   = wb_q.mem_to_reg;
  assign bus.wb_funct3     = wb_q.funct3;
  assign bus.wb_rd         = wb_q.rd;
  assign bus.wb_Mem_out    = wb_q.mem_out;
  assign bus.wb_rd_data    = wb_q.rd_data;
  assign bus.wb_misaligned = wb_q.misaligned;
  assign bus.wb_bus_err    = wb_q.bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors with literal expectations, plus a
// per-cycle comparison against a behavioural model of the stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TMO  = 4;
  localparam int WB_W = 77;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [WB_W-1:0] exp_q[$];
  int              waited = 0;
  logic [WB_W-1:0] dut_wb;

  assign dut_wb = {bus.wb_valid, bus.wb_RegWrite, bus.wb_MemtoReg, bus.wb_funct3,
                   bus.wb_rd, bus.wb_Mem_out, bus.wb_rd_data, bus.wb_misaligned,
                   bus.wb_bus_err};

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ex(input logic v, input logic rd_en, input logic wr_en,
                        input logic rw, input logic m2r, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] rs2);
    bus.ex_valid      = v;
    bus.ex_MemRead    = rd_en;
    bus.ex_MemWrite   = wr_en;
    bus.ex_RegWrite   = rw;
    bus.ex_MemtoReg   = m2r;
    bus.ex_funct3     = f3;
    bus.ex_rd         = rd;
    bus.ex_alu_result = alu;
    bus.ex_rs2_data   = rs2;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model + scoreboard ----------------
  always @(negedge clk) begin : cmp
    logic [1:0]      sz;
    logic [1:0]      off;
    logic            mop, mis, e_req, tmo, e_stall, rw;
    logic [3:0]      e_strb;
    logic [31:0]     e_wdata, memout;
    logic [WB_W-1:0] rec;
    if (rst) begin
      chk("rst_req", 80'(bus.dmem_req), 80'(1'b0));
      chk("rst_stall", 80'(bus.mem_stall), 80'(1'b0));
      chk("rst_wb", 80'(dut_wb), 80'(0));
      exp_q = {};
      exp_q.push_back('0);
      waited = 0;
    end else begin
      if (exp_q.size() > 0) chk("wb_reg", 80'(dut_wb), 80'(exp_q.pop_front()));
      sz  = bus.ex_funct3[1:0];
      off = bus.ex_alu_result[1:0];
      mop = bus.ex_valid && (bus.ex_MemRead || bus.ex_MemWrite);
      mis = mop && ((sz == 2'd1 && off[0]) || (sz >= 2'd2 && off != 2'd0));
      // an access that has already waited keeps requesting
      e_req   = (waited > 0) || (mop && !mis);
      tmo     = (waited > 0) && (waited == TMO) && !bus.dmem_ready;
      e_stall = e_req && !bus.dmem_ready && !tmo;
      chk("bus_req", 80'(bus.dmem_req), 80'(e_req));
      chk("stall", 80'(bus.mem_stall), 80'(e_stall));
      if (e_req) begin
        if (!bus.ex_MemWrite) e_strb = 4'b0000;
        else if (sz == 2'd0)  e_strb = 4'b0001 << off;
        else if (sz == 2'd1)  e_strb = 4'b0011 << off;
        else                  e_strb = 4'b1111;
        if (sz == 2'd0)      e_wdata = {4{bus.ex_rs2_data[7:0]}};
        else if (sz == 2'd1) e_wdata = {2{bus.ex_rs2_data[15:0]}};
        else                 e_wdata = bus.ex_rs2_data;
        chk("bus_addr", 80'(bus.dmem_addr), 80'(bus.ex_alu_result & 32'hFFFF_FFFC));
        chk("bus_we", 80'(bus.dmem_we), 80'(bus.ex_MemWrite));
        chk("bus_wstrb", 80'(bus.dmem_wstrb), 80'(e_strb));
        if (bus.ex_MemWrite) chk("bus_wdata", 80'(bus.dmem_wdata), 80'(e_wdata));
      end
      if (e_stall || !bus.ex_valid) begin
        rec = '0;
      end else begin
        rw     = bus.ex_RegWrite && !bus.ex_MemWrite && !mis && !tmo;
        memout = (mop && bus.ex_MemRead && !bus.ex_MemWrite && !mis && !tmo) ?
                 (bus.dmem_rdata >> (8 * int'(off))) : 32'd0;
        rec = {1'b1, rw, bus.ex_MemtoReg, bus.ex_funct3, bus.ex_rd, memout,
               bus.ex_alu_result, mis, tmo};
      end
      exp_q.push_back(rec);
      waited = e_stall ? waited + 1 : 0;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // SW 0xDEADBEEF to 0x100, zero wait states
    set_ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, F3_SW, 5'd3, 32'h100, 32'hDEADBEEF);
    bus.dmem_ready = 1'b1;
    #1;
    chk("sw_req", 80'(bus.dmem_req), 80'(1'b1));
    chk("sw_wstrb", 80'(bus.dmem_wstrb), 80'(4'b1111));
    chk("sw_wdata", 80'(bus.dmem_wdata), 80'(32'hDEADBEEF));
    chk("sw_addr", 80'(bus.dmem_addr), 80'(32'h100));
    chk("sw_stall", 80'(bus.mem_stall), 80'(1'b0));
    cycle();
    chk("sw_wb_valid", 80'(bus.wb_valid), 80'(1'b1));
    chk("sw_wb_regwrite", 80'(bus.wb_RegWrite), 80'(1'b0));

    // LB from 0x103 with three wait states
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, F3_LB, 5'd7, 32'h103, 32'd0);
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'h80AABBCC;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lb_stall", 80'(bus.mem_stall), 80'(1'b1));
      chk("lb_addr", 80'(bus.dmem_addr), 80'(32'h100));
      cycle();
      chk("lb_bubble", 80'(bus.wb_valid), 80'(1'b0));
    end
    bus.dmem_ready = 1'b1;
    #1 chk("lb_ready_nostall", 80'(bus.mem_stall), 80'(1'b0));
    cycle();
    chk("lb_mem_out", 80'(bus.wb_Mem_out), 80'(32'h00000080));
    chk("lb_funct3", 80'(bus.wb_funct3), 80'(3'b000));
    chk("lb_rd", 80'(bus.wb_rd), 80'(5'd7));

    // SH 0x1234 to 0x102
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, F3_SH, 5'd0, 32'h102, 32'hABCD1234);
    #1;
    chk("sh_wstrb", 80'(bus.dmem_wstrb), 80'(4'b1100));
    chk("sh_wdata", 80'(bus.dmem_wdata), 80'(32'h12341234));
    cycle();
    chk("sh_wb_regwrite", 80'(bus.wb_RegWrite), 80'(1'b0));

    // SB 0x5A to 0x101
    set_ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, F3_SB, 5'd0, 32'h101, 32'h1234565A);
    #1;
    chk("sb_wstrb", 80'(bus.dmem_wstrb), 80'(4'b0010));
    chk("sb_wdata", 80'(bus.dmem_wdata), 80'(32'h5A5A5A5A));
    cycle();

    // LH to 0x101: misaligned, no bus request, no stall
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, F3_LH, 5'd8, 32'h101, 32'd0);
    bus.dmem_ready = 1'b0;
    #1;
    chk("lh_req", 80'(bus.dmem_req), 80'(1'b0));
    chk("lh_stall", 80'(bus.mem_stall), 80'(1'b0));
    cycle();
    chk("lh_mis", 80'(bus.wb_misaligned), 80'(1'b1));
    chk("lh_regwrite", 80'(bus.wb_RegWrite), 80'(1'b0));
    chk("lh_valid", 80'(bus.wb_valid), 80'(1'b1));

    // LW to 0x200, ready never comes: abort after TMO wait cycles
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, F3_LW, 5'd9, 32'h200, 32'd0);
    bus.dmem_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < TMO; k++) begin
      #1 chk("to_stall", 80'(bus.mem_stall), 80'(1'b1));
      cycle();
    end
    #1;
    chk("to_release", 80'(bus.mem_stall), 80'(1'b0));
    chk("to_req_held", 80'(bus.dmem_req), 80'(1'b1));
    chk("to_state_busy", 80'(bus.dbg_state), 80'(ST_BUSY));
    cycle();
    chk("to_bus_err", 80'(bus.wb_bus_err), 80'(1'b1));
    chk("to_mem_out", 80'(bus.wb_Mem_out), 80'(32'd0));
    chk("to_regwrite", 80'(bus.wb_RegWrite), 80'(1'b0));
    chk("to_state_idle", 80'(bus.dbg_state), 80'(ST_IDLE));
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    #1 chk("to_req_drop", 80'(bus.dmem_req), 80'(1'b0));
    cycle();

    // LW to 0x204 with ready arriving in the timeout cycle: success wins
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, F3_LW, 5'd10, 32'h204, 32'd0);
    bus.dmem_rdata = 32'h11223344;
    repeat (TMO) cycle();
    bus.dmem_ready = 1'b1;
    #1 chk("tie_stall", 80'(bus.mem_stall), 80'(1'b0));
    cycle();
    chk("tie_bus_err", 80'(bus.wb_bus_err), 80'(1'b0));
    chk("tie_mem_out", 80'(bus.wb_Mem_out), 80'(32'h11223344));
    chk("tie_regwrite", 80'(bus.wb_RegWrite), 80'(1'b1));

    // LHU from 0x206, zero wait states
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, F3_LHU, 5'd11, 32'h206, 32'd0);
    bus.dmem_rdata = 32'hAABBCCDD;
    cycle();
    chk("lhu_mem_out", 80'(bus.wb_Mem_out), 80'(32'h0000AABB));
    chk("lhu_funct3", 80'(bus.wb_funct3), 80'(F3_LHU));

    // ALU op passes through, then an empty slot
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd12, 32'h55, 32'd0);
    cycle();
    chk("alu_rd", 80'(bus.wb_rd), 80'(5'd12));
    chk("alu_rd_data", 80'(bus.wb_rd_data), 80'(32'h55));
    chk("alu_mem_out", 80'(bus.wb_Mem_out), 80'(32'd0));
    set_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd13, 32'h66, 32'd0);
    cycle();
    chk("bubble_valid", 80'(bus.wb_valid), 80'(1'b0));

    // Reset asserted while an access is in BUSY
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, F3_LW, 5'd14, 32'h300, 32'd0);
    bus.dmem_ready = 1'b0;
    cycle();
    #1 chk("rb_state_busy", 80'(bus.dbg_state), 80'(ST_BUSY));
    rst = 1'b1;
    #1;
    chk("rb_req", 80'(bus.dmem_req), 80'(1'b0));
    chk("rb_stall", 80'(bus.mem_stall), 80'(1'b0));
    chk("rb_wb", 80'(dut_wb), 80'(0));
    chk("rb_state", 80'(bus.dbg_state), 80'(ST_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd5, 32'd7, 32'd0);
    cycle();
    chk("add_rd", 80'(bus.wb_rd), 80'(5'd5));
    chk("add_rd_data", 80'(bus.wb_rd_data), 80'(32'd7));
    chk("add_valid", 80'(bus.wb_valid), 80'(1'b1));
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
